// File: rtl/fp_mul_seq_param.sv
// Parametrised sequential floating-point multiplier with a one-bit-per-cycle shift-add core.
// The result is rounded to nearest even, special operands are handled, and busy/doneMul form the handshake.
module fp_mul_seq_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   startMul,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   doneMul,
  output logic                   busy,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int PW    = 2 * SIG_W;
  localparam int XW    = EXP_W + 2;
  localparam int CNT_W = $clog2(SIG_W + 1);
  localparam int BIAS  = 2**(EXP_W-1) - 1;

  localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
  localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;

  state_t                  state_q;
  logic                    sign_q;
  logic [EXP_W-1:0]        ea_q, eb_q;
  logic [SIG_W-1:0]        ma_q;
  logic [PW-1:0]           prod_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    nan_q, inf_q, zero_q;
  logic signed [XW-1:0]    exp_q;
  logic [MAN_W-1:0]        man_q;
  logic                    grd_q, rnd_q, stk_q;
  logic [W-1:0]            result_q;
  logic                    done_q, busy_q, ovf_q, unf_q, inv_q;

  // operand classification
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic [SIG_W-1:0] sig_a, sig_b;

  assign a_exp  = A[W-2 -: EXP_W];
  assign b_exp  = B[W-2 -: EXP_W];
  assign a_man  = A[MAN_W-1:0];
  assign b_man  = B[MAN_W-1:0];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_nan  = (a_exp == '1) &&  (|a_man);
  assign b_nan  = (b_exp == '1) &&  (|b_man);
  assign a_inf  = (a_exp == '1) && !(|a_man);
  assign b_inf  = (b_exp == '1) && !(|b_man);
  assign sig_a  = a_zero ? '0 : {1'b1, a_man};
  assign sig_b  = b_zero ? '0 : {1'b1, b_man};

  // Multiplier lives in the low half of prod_q and is consumed LSB-first as the sum shifts in.
  logic [SIG_W:0]  step_sum;
  logic [PW-1:0]   step_prod;
  assign step_sum  = {1'b0, prod_q[PW-1:SIG_W]} + (prod_q[0] ? {1'b0, ma_q} : '0);
  assign step_prod = {step_sum, prod_q[SIG_W-1:1]};

  // Left-justify instead of right-shifting so no product bit is lost before sticky is formed.
  logic [PW-2:0]        norm;
  logic signed [XW-1:0] exp_sum;
  assign norm    = prod_q[PW-1] ? prod_q[PW-2:0] : {prod_q[PW-3:0], 1'b0};
  assign exp_sum = {2'b00, ea_q} + {2'b00, eb_q} - BIAS_X + {{(XW-1){1'b0}}, prod_q[PW-1]};

  logic                 rnd_inc;
  logic [MAN_W:0]       man_rnd;
  logic signed [XW-1:0] exp_rnd;
  assign rnd_inc = grd_q & (rnd_q | stk_q | man_q[0]);
  assign man_rnd = {1'b0, man_q} + {{MAN_W{1'b0}}, rnd_inc};
  assign exp_rnd = exp_q + {{(XW-1){1'b0}}, man_rnd[MAN_W]};

  logic [W-1:0] pk_res;
  logic         pk_ovf, pk_unf, pk_inv;

  always_comb begin
    pk_res = {sign_q, exp_rnd[EXP_W-1:0], man_rnd[MAN_W-1:0]};
    pk_ovf = 1'b0;
    pk_unf = 1'b0;
    pk_inv = 1'b0;
    if (nan_q) begin
      pk_res = QNAN;
      pk_inv = 1'b1;
    end else if (inf_q) begin
      pk_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_q) begin
      pk_res = {sign_q, {(W-1){1'b0}}};
    end else if (exp_rnd >= EMAX_X) begin
      pk_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      pk_ovf = 1'b1;
    end else if (exp_rnd[XW-1] || (exp_rnd == '0)) begin
      pk_res = {sign_q, {(W-1){1'b0}}};
      pk_unf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      ma_q     <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      nan_q    <= 1'b0;
      inf_q    <= 1'b0;
      zero_q   <= 1'b0;
      exp_q    <= '0;
      man_q    <= '0;
      grd_q    <= 1'b0;
      rnd_q    <= 1'b0;
      stk_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startMul) begin
            sign_q  <= A[W-1] ^ B[W-1];
            ea_q    <= a_exp;
            eb_q    <= b_exp;
            ma_q    <= sig_a;
            prod_q  <= {{SIG_W{1'b0}}, sig_b};
            cnt_q   <= '0;
            nan_q   <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
            inf_q   <= a_inf | b_inf;
            zero_q  <= a_zero | b_zero;
            busy_q  <= 1'b1;
            state_q <= MUL;
          end
        end
        MUL: begin
          prod_q <= step_prod;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SIG_W - 1)) state_q <= NORM;
        end
        NORM: begin
          exp_q   <= exp_sum;
          man_q   <= norm[PW-2 -: MAN_W];
          grd_q   <= norm[MAN_W];
          rnd_q   <= norm[MAN_W-1];
          stk_q   <= |norm[MAN_W-2:0];
          state_q <= ROUND;
        end
        ROUND: begin
          result_q <= pk_res;
          ovf_q    <= pk_ovf;
          unf_q    <= pk_unf;
          inv_q    <= pk_inv;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result    = result_q;
  assign doneMul   = done_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;

endmodule

// File: tb/tb_fp_mul_seq_param.sv
// Self-checking bench: single- and half-precision instances, table vectors, scoreboard on doneMul.
module tb_fp_mul_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [31:0] A0, B0, result0;
  logic [15:0] A1, B1, result1;
  logic        done0, busy0, ovf0, unf0, inv0;
  logic        done1, busy1, ovf1, unf1, inv1;

  always #5 clk = ~clk;

  fp_mul_seq_param dut0 (
    .clk(clk), .rst(rst), .startMul(start0), .A(A0), .B(B0), .result(result0),
    .doneMul(done0), .busy(busy0), .overflow(ovf0), .underflow(unf0), .invalid(inv0)
  );

  fp_mul_seq_param #(.EXP_W(5), .MAN_W(10)) dut1 (
    .clk(clk), .rst(rst), .startMul(start1), .A(A1), .B(B1), .result(result1),
    .doneMul(done1), .busy(busy1), .overflow(ovf1), .underflow(unf1), .invalid(inv1)
  );

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;   // {overflow, underflow, invalid}
    string       name;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] a, b, res;
    logic [2:0]  flg;
  } vec_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt0 = 0;
  int   done_cnt1 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && done0 === 1'b1) begin
      exp_t e;
      done_cnt0++;
      if (sb0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done0: got doneMul=1 expected no completion");
      end else begin
        e = sb0.pop_front();
        chk({e.name, "_result"}, 64'(result0), 64'(e.res));
        chk({e.name, "_flags"}, 64'({ovf0, unf0, inv0}), 64'(e.flg));
      end
    end
    if (rst === 1'b1 && done1 === 1'b1) begin
      exp_t e;
      done_cnt1++;
      if (sb1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done1: got doneMul=1 expected no completion");
      end else begin
        e = sb1.pop_front();
        chk({e.name, "_result"}, 64'(result1), 64'(e.res[15:0]));
        chk({e.name, "_flags"}, 64'({ovf1, unf1, inv1}), 64'(e.flg));
      end
    end
  end

  task automatic run0(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic [2:0] flg);
    exp_t e;
    int unsigned n;
    logic busy_ok;
    @(negedge clk);
    A0 = a; B0 = b; start0 = 1'b1;
    e.res = res; e.flg = flg; e.name = nm;
    sb0.push_back(e);
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0; busy_ok = 1'b1;
    while (done0 !== 1'b1 && n < 60) begin
      busy_ok &= busy0;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(26));
    chk({nm, "_busy"}, 64'(busy_ok & busy0), 64'(1));
    @(posedge clk); #1;
    chk({nm, "_idle"}, 64'({busy0, done0}), 64'(0));
  endtask

  task automatic run1(input string nm, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] res, input logic [2:0] flg);
    exp_t e;
    int unsigned n;
    @(negedge clk);
    A1 = a; B1 = b; start1 = 1'b1;
    e.res = {16'h0, res}; e.flg = flg; e.name = nm;
    sb1.push_back(e);
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(13));
    @(posedge clk); #1;
    chk({nm, "_idle"}, 64'({busy1, done1}), 64'(0));
  endtask

  vec_t vecs[16];

  initial begin
    int unsigned n;
    int dc;
    vecs[0]  = '{"basic",      32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000};
    vecs[1]  = '{"sign",       32'hBFC00000, 32'h40000000, 32'hC0400000, 3'b000};
    vecs[2]  = '{"near_one",   32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000};
    vecs[3]  = '{"rne_up",     32'h3FC00001, 32'h3FC00001, 32'h40100002, 3'b000};
    vecs[4]  = '{"tie_odd",    32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000};
    vecs[5]  = '{"tie_even",   32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000};
    vecs[6]  = '{"msb_norm",   32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 3'b000};
    vecs[7]  = '{"inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001};
    vecs[8]  = '{"zero_x_inf", 32'h00000000, 32'hFF800000, 32'h7FC00000, 3'b001};
    vecs[9]  = '{"nan_in",     32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b001};
    vecs[10] = '{"neg_zero",   32'h80000000, 32'h3F800000, 32'h80000000, 3'b000};
    vecs[11] = '{"neg_inf",    32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000};
    vecs[12] = '{"overflow",   32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100};
    vecs[13] = '{"underflow",  32'h00800000, 32'h3F000000, 32'h00000000, 3'b010};
    vecs[14] = '{"neg_unf",    32'h80800000, 32'h3F000000, 32'h80000000, 3'b010};
    vecs[15] = '{"denorm",     32'h00400000, 32'h3F800000, 32'h00000000, 3'b000};

    rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dut0", 64'({result0, done0, busy0, ovf0, unf0, inv0}), 64'(0));
    chk("reset_dut1", 64'({result1, done1, busy1, ovf1, unf1, inv1}), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run0(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg);

    // second start while busy, with operands changed mid-flight
    dc = done_cnt0;
    begin
      exp_t e;
      @(negedge clk);
      A0 = 32'h3FC00000; B0 = 32'h40000000; start0 = 1'b1;
      e.res = 32'h40400000; e.flg = 3'b000; e.name = "hs_ignore";
      sb0.push_back(e);
      @(posedge clk); #1;
      start0 = 1'b0;
      n = 0;
      while (done0 !== 1'b1 && n < 60) begin
        if (n == 3) begin
          start0 = 1'b1; A0 = 32'h40000000; B0 = 32'h40000000;
        end else begin
          start0 = 1'b0;
        end
        @(posedge clk); #1;
        n++;
      end
      start0 = 1'b0;
      chk("hs_latency", 64'(n), 64'(26));
      repeat (40) @(posedge clk);
      #1;
      chk("hs_single_done", 64'(done_cnt0 - dc), 64'(1));
    end

    // asynchronous reset in the middle of MUL
    @(negedge clk);
    A0 = 32'h3FC00000; B0 = 32'h40000000; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_async_outs", 64'({result0, done0, busy0, ovf0, unf0, inv0}), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dc = done_cnt0;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_no_done", 64'(done_cnt0 - dc), 64'(0));
    chk("rst_idle_busy", 64'(busy0), 64'(0));
    run0("after_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);

    // half precision instance
    run1("half_basic", 16'h3E00, 16'h4000, 16'h4200, 3'b000);
    run1("half_ovf",   16'h7BFF, 16'h4000, 16'h7C00, 3'b100);

    repeat (5) @(posedge clk);
    #1;
    chk("sb0_drained", 64'(sb0.size()), 64'(0));
    chk("sb1_drained", 64'(sb1.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
